tictactoe_game_ctrl: RTL and testbench

- Game-sequencing controller for the VGA tic-tac-toe display.
- Owns the 3x3 board state, the cursor, and the player turn; evaluates win and draw.
- Exports board, cursor and result to the sprite/line renderers, which decide what to draw per cell.
- Runs on the pixel clock domain (vga_clk); inputs are already synchronized and debounced.

---
 rtl/tictactoe_pkg.sv | 38 +++
 rtl/tictactoe_line_checker.sv | 27 ++
 rtl/tictactoe_game_ctrl.sv | 147 ++++++++++++++
 tb/tb_tictactoe_game_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tictactoe_pkg.sv
// Shared cell, phase and result encodings plus the eight winning lines
// used by the tic-tac-toe game controller.
package tictactoe_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    MARK_X = 2'b01,
    MARK_O = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    CHECK = 2'd2,
    OVER  = 2'd3
  } phase_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  localparam int NUM_CELLS = 9;
  localparam int NUM_LINES = 8;

  // Cell-index triplets: three rows, three columns, two diagonals.
  localparam int LINES [NUM_LINES][3] = '{
    '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
    '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
    '{0, 4, 8}, '{2, 4, 6}
  };

  // Player 1 marks X, player 2 marks O; the mark code doubles as the winner code.
  function automatic cell_t mark_of(input logic turn);
    return turn ? MARK_O : MARK_X;
  endfunction

endpackage

// File: rtl/tictactoe_line_checker.sv
// Combinational board evaluation: does `mark` own any complete line,
// and are all nine cells occupied.
module tictactoe_line_checker
  import tictactoe_pkg::*;
(
  input  logic [17:0] board,
  input  cell_t       mark,
  output logic        win,
  output logic        full
);

  always_comb begin
    win  = 1'b0;
    full = 1'b1;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (board[2*LINES[i][0] +: 2] == mark &&
          board[2*LINES[i][1] +: 2] == mark &&
          board[2*LINES[i][2] +: 2] == mark)
        win = 1'b1;
    end
    for (int c = 0; c < NUM_CELLS; c++) begin
      if (board[2*c +: 2] == EMPTY)
        full = 1'b0;
    end
  end

endmodule

// File: rtl/tictactoe_game_ctrl.sv
// Game sequencer for the VGA tic-tac-toe: owns board, cursor, turn and result,
// handles button edges, the per-turn timeout and win/draw evaluation.
module tictactoe_game_ctrl
  import tictactoe_pkg::*;
#(
  parameter int TIMEOUT_TICKS = 600,
  parameter int TIMER_W       = 10,
  parameter int START_CURSOR  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_start,
  input  logic        btn_next,
  input  logic        btn_sel,
  input  logic        tick,
  output logic [17:0] board,
  output logic [3:0]  cursor,
  output logic        turn,
  output logic [1:0]  winner,
  output logic        game_over,
  output logic [1:0]  phase
);

  localparam logic [3:0]         START_CELL = 4'(START_CURSOR);
  // With the timeout disabled this wraps to all-ones, which is where the timer saturates.
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_TICKS - 1);
  localparam bit                 TIMEOUT_ON = (TIMEOUT_TICKS != 0);

  phase_t             state_q, state_d;
  logic [17:0]        board_q, board_d;
  logic [3:0]         cursor_q, cursor_d;
  logic               turn_q, turn_d;
  logic [1:0]         winner_q, winner_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [2:0]         hist_q;

  logic  start_edge, next_edge, sel_edge;
  logic  cursor_empty, timeout;
  logic  win, full;
  logic  [3:0] free_cell;
  cell_t mark;

  assign start_edge   = btn_start & ~hist_q[0];
  assign next_edge    = btn_next  & ~hist_q[1];
  assign sel_edge     = btn_sel   & ~hist_q[2];
  assign mark         = mark_of(turn_q);
  assign cursor_empty = (board_q[{cursor_q, 1'b0} +: 2] == EMPTY);
  assign timeout      = TIMEOUT_ON && tick && (timer_q == TIMER_LAST);

  // Lowest-index empty cell, the target of an automatic placement.
  always_comb begin
    free_cell = 4'd0;
    for (int c = NUM_CELLS - 1; c >= 0; c--) begin
      if (board_q[2*c +: 2] == EMPTY)
        free_cell = 4'(c);
    end
  end

  tictactoe_line_checker u_checker (
    .board (board_q),
    .mark  (mark),
    .win   (win),
    .full  (full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      board_q  <= '0;
      cursor_q <= START_CELL;
      turn_q   <= 1'b0;
      winner_q <= WIN_NONE;
      timer_q  <= '0;
      hist_q   <= '0;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      cursor_q <= cursor_d;
      turn_q   <= turn_d;
      winner_q <= winner_d;
      timer_q  <= timer_d;
      hist_q   <= {btn_sel, btn_next, btn_start};
    end
  end

  // A start edge anywhere except CHECK begins a fresh game; it outranks every other action.
  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    cursor_d = cursor_q;
    turn_d   = turn_q;
    winner_d = winner_q;
    timer_d  = timer_q;

    if (start_edge && state_q != CHECK) begin
      state_d  = PLAY;
      board_d  = '0;
      cursor_d = START_CELL;
      turn_d   = 1'b0;
      winner_d = WIN_NONE;
      timer_d  = '0;
    end else begin
      case (state_q)
        IDLE: board_d = '0;
        PLAY: begin
          if (sel_edge && cursor_empty) begin
            board_d[{cursor_q, 1'b0} +: 2] = mark;
            timer_d = '0;
            state_d = CHECK;
          end else if (timeout) begin
            board_d[{free_cell, 1'b0} +: 2] = mark;
            cursor_d = free_cell;
            timer_d  = '0;
            state_d  = CHECK;
          end else begin
            if (next_edge && !sel_edge)
              cursor_d = (cursor_q == 4'd8) ? 4'd0 : cursor_q + 4'd1;
            if (tick && timer_q != TIMER_LAST)
              timer_d = timer_q + TIMER_W'(1);
          end
        end
        CHECK: begin
          if (win) begin
            winner_d = mark;
            state_d  = OVER;
          end else if (full) begin
            winner_d = WIN_DRAW;
            state_d  = OVER;
          end else begin
            turn_d  = ~turn_q;
            state_d = PLAY;
          end
        end
        OVER: ;
        default: state_d = IDLE;
      endcase
    end
  end

  assign board     = board_q;
  assign cursor    = cursor_q;
  assign turn      = turn_q;
  assign winner    = winner_q;
  assign game_over = (state_q == OVER);
  assign phase     = state_q;

endmodule

// File: tb/tb_tictactoe_game_ctrl.sv
// Self-checking bench for tictactoe_game_ctrl: a vector table for a full winning
// game, hand sequences for timing corners, then random play against a model.
module tb_tictactoe_game_ctrl;

  localparam int TO = 3;
  localparam int TW = 2;

  logic clk = 1'b0;
  logic rst;
  logic btn_start, btn_next, btn_sel, tick;
  logic [17:0] board;
  logic [3:0]  cursor;
  logic        turn;
  logic [1:0]  winner;
  logic        game_over;
  logic [1:0]  phase;

  int n_vec = 0;
  int n_mis = 0;
  int tb_cursor;

  always #5 clk = ~clk;

  tictactoe_game_ctrl #(
    .TIMEOUT_TICKS (TO),
    .TIMER_W       (TW),
    .START_CURSOR  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_start (btn_start),
    .btn_next  (btn_next),
    .btn_sel   (btn_sel),
    .tick      (tick),
    .board     (board),
    .cursor    (cursor),
    .turn      (turn),
    .winner    (winner),
    .game_over (game_over),
    .phase     (phase)
  );

  typedef struct {
    logic s, n, p, t;
    logic [17:0] b;
    logic [3:0]  c;
    logic        tr;
    logic [1:0]  w;
    logic [1:0]  ph;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: cells hold 0 empty, 1 X, 2 O; phase 0..3 = idle/play/check/over.
  int m_cells[9];
  int m_phase, m_cursor, m_turn, m_winner, m_timer;
  bit m_ps, m_pn, m_pp;

  task automatic check_output(input string name, input logic [17:0] eb, input logic [3:0] ec,
                              input logic et, input logic [1:0] ew, input logic [1:0] ep);
    n_vec++;
    if (board !== eb || cursor !== ec || turn !== et || winner !== ew || phase !== ep ||
        game_over !== (ep == 2'd3)) begin
      n_mis++;
      $display("[TB] FAIL %s: got board=%05h cursor=%0d turn=%0d winner=%0d phase=%0d over=%0d; want board=%05h cursor=%0d turn=%0d winner=%0d phase=%0d",
               name, board, cursor, turn, winner, phase, game_over, eb, ec, et, ew, ep);
    end
  endtask

  task automatic apply_stimulus(input logic s, input logic n, input logic p, input logic t);
    btn_start = s; btn_next = n; btn_sel = p; tick = t;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic s, input logic n, input logic p, input logic t);
    apply_stimulus(s, n, p, t);
    apply_stimulus(0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0);
  endtask

  task automatic new_game();
    pulse(1, 0, 0, 0);
    tb_cursor = 4;
  endtask

  task automatic press_next();
    pulse(0, 1, 0, 0);
    tb_cursor = (tb_cursor + 1) % 9;
  endtask

  task automatic place_at(input int c);
    for (int k = 0; k < 9 && tb_cursor != c; k++) press_next();
    pulse(0, 0, 1, 0);
  endtask

  function automatic void add_vec(input logic s, input logic n, input logic p, input logic t,
                                  input logic [17:0] b, input logic [3:0] c, input logic tr,
                                  input logic [1:0] w, input logic [1:0] ph);
    vec_t v;
    v.s = s; v.n = n; v.p = p; v.t = t;
    v.b = b; v.c = c; v.tr = tr; v.w = w; v.ph = ph;
    vecs.push_back(v);
  endfunction

  function automatic void add_nexts(input int from, input int cnt, input logic [17:0] b, input logic tr);
    int c = from;
    for (int k = 0; k < cnt; k++) begin
      c = (c + 1) % 9;
      add_vec(0, 1, 0, 0, b, 4'(c), tr, 2'b00, 2'd1);
    end
  endfunction

  function automatic logic [17:0] pack_model();
    logic [17:0] r = '0;
    for (int i = 0; i < 9; i++) r[2*i +: 2] = 2'(m_cells[i]);
    return r;
  endfunction

  function automatic bit line_won(input int mk);
    bit w = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (m_cells[3*k] == mk && m_cells[3*k+1] == mk && m_cells[3*k+2] == mk) w = 1'b1;
      if (m_cells[k] == mk && m_cells[k+3] == mk && m_cells[k+6] == mk) w = 1'b1;
    end
    if (m_cells[4] == mk && ((m_cells[0] == mk && m_cells[8] == mk) ||
                             (m_cells[2] == mk && m_cells[6] == mk))) w = 1'b1;
    return w;
  endfunction

  function automatic void model_new_game();
    foreach (m_cells[i]) m_cells[i] = 0;
    m_phase = 1; m_cursor = 4; m_turn = 0; m_winner = 0; m_timer = 0;
  endfunction

  function automatic void model_reset();
    model_new_game();
    m_phase = 0;
    m_ps = 0; m_pn = 0; m_pp = 0;
  endfunction

  function automatic void model_step(input bit s, input bit n, input bit p, input bit t);
    bit es, en, ep, full;
    int mark, lo;
    es = s && !m_ps; en = n && !m_pn; ep = p && !m_pp;
    m_ps = s; m_pn = n; m_pp = p;
    mark = m_turn + 1;
    if (m_phase != 2 && es) begin
      model_new_game();
    end else if (m_phase == 1) begin
      if (ep && m_cells[m_cursor] == 0) begin
        m_cells[m_cursor] = mark; m_timer = 0; m_phase = 2;
      end else if (t && TO != 0 && m_timer + 1 == TO) begin
        lo = 0;
        while (lo < 8 && m_cells[lo] != 0) lo++;
        m_cells[lo] = mark; m_cursor = lo; m_timer = 0; m_phase = 2;
      end else begin
        if (en && !ep) m_cursor = (m_cursor + 1) % 9;
        if (t && (TO != 0 || m_timer < (1 << TW) - 1)) m_timer++;
      end
    end else if (m_phase == 2) begin
      full = 1'b1;
      foreach (m_cells[i]) if (m_cells[i] == 0) full = 1'b0;
      if (line_won(mark)) begin
        m_winner = mark; m_phase = 3;
      end else if (full) begin
        m_winner = 3; m_phase = 3;
      end else begin
        m_turn = 1 - m_turn; m_phase = 1;
      end
    end
  endfunction

  initial begin
    bit s, n, p;
    rst = 1'b0;
    btn_start = 0; btn_next = 0; btn_sel = 0; tick = 0;
    tb_cursor = 4;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check_output("reset_state", 18'h0, 4'd4, 1'b0, 2'b00, 2'd0);

    // Winning game for P1 on the 0-4-8 diagonal, then OVER hold and restart.
    add_vec(1, 0, 0, 0, 18'h00000, 4'd4, 0, 2'b00, 2'd1);
    add_vec(0, 0, 1, 0, 18'h00100, 4'd4, 1, 2'b00, 2'd1);
    add_nexts(4, 1, 18'h00100, 1);
    add_vec(0, 0, 1, 0, 18'h00900, 4'd5, 0, 2'b00, 2'd1);
    add_nexts(5, 4, 18'h00900, 0);
    add_vec(0, 0, 1, 0, 18'h00901, 4'd0, 1, 2'b00, 2'd1);
    add_nexts(0, 3, 18'h00901, 1);
    add_vec(0, 0, 1, 0, 18'h00981, 4'd3, 0, 2'b00, 2'd1);
    add_nexts(3, 5, 18'h00981, 0);
    add_vec(0, 0, 1, 0, 18'h10981, 4'd8, 0, 2'b01, 2'd3);
    add_vec(0, 0, 1, 0, 18'h10981, 4'd8, 0, 2'b01, 2'd3);
    add_vec(0, 1, 0, 0, 18'h10981, 4'd8, 0, 2'b01, 2'd3);
    add_vec(1, 0, 0, 0, 18'h00000, 4'd4, 0, 2'b00, 2'd1);
    add_vec(0, 0, 1, 0, 18'h00100, 4'd4, 1, 2'b00, 2'd1);
    add_vec(0, 0, 1, 0, 18'h00100, 4'd4, 1, 2'b00, 2'd1);
    for (int i = 0; i < vecs.size(); i++) begin
      pulse(vecs[i].s, vecs[i].n, vecs[i].p, vecs[i].t);
      check_output($sformatf("vec%0d", i), vecs[i].b, vecs[i].c, vecs[i].tr, vecs[i].w, vecs[i].ph);
    end

    // Asynchronous reset mid-game, then sel/next ignored in IDLE.
    #2 rst = 1'b0;
    #1 check_output("async_reset", 18'h0, 4'd4, 1'b0, 2'b00, 2'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    pulse(0, 0, 1, 0);
    pulse(0, 1, 0, 0);
    check_output("idle_ignores", 18'h0, 4'd4, 1'b0, 2'b00, 2'd0);

    // Placement latency, start discarded in CHECK, held buttons act once.
    new_game();
    apply_stimulus(0, 0, 1, 0);
    check_output("sel_n_plus_1", 18'h00100, 4'd4, 1'b0, 2'b00, 2'd2);
    apply_stimulus(1, 0, 0, 0);
    check_output("start_in_check", 18'h00100, 4'd4, 1'b1, 2'b00, 2'd1);
    apply_stimulus(1, 0, 0, 0);
    check_output("start_held", 18'h00100, 4'd4, 1'b1, 2'b00, 2'd1);
    apply_stimulus(0, 0, 0, 0);
    repeat (3) apply_stimulus(0, 1, 0, 0);
    check_output("next_held", 18'h00100, 4'd5, 1'b1, 2'b00, 2'd1);
    apply_stimulus(0, 0, 0, 0);

    // sel and next together at cursor 8.
    new_game();
    for (int k = 0; k < 9 && tb_cursor != 8; k++) press_next();
    pulse(0, 1, 1, 0);
    check_output("sel_next_same", 18'h10000, 4'd8, 1'b1, 2'b00, 2'd1);

    // Timeout placement, restart with marks on board, sel beating the timeout.
    new_game();
    place_at(0);
    place_at(1);
    pulse(0, 0, 0, 1);
    pulse(0, 0, 0, 1);
    check_output("pre_timeout", 18'h00009, 4'd1, 1'b0, 2'b00, 2'd1);
    pulse(0, 0, 0, 1);
    check_output("timeout", 18'h00019, 4'd2, 1'b1, 2'b00, 2'd1);
    apply_stimulus(1, 0, 0, 0);
    check_output("restart_play", 18'h0, 4'd4, 1'b0, 2'b00, 2'd1);
    apply_stimulus(0, 0, 0, 0);
    tb_cursor = 4;
    place_at(0);
    place_at(1);
    for (int k = 0; k < 9 && tb_cursor != 5; k++) press_next();
    pulse(0, 0, 0, 1);
    pulse(0, 0, 0, 1);
    pulse(0, 0, 1, 1);
    check_output("sel_beats_timeout", 18'h00409, 4'd5, 1'b1, 2'b00, 2'd1);
    pulse(0, 0, 0, 1);
    pulse(0, 0, 0, 1);
    check_output("timer_cleared", 18'h00409, 4'd5, 1'b1, 2'b00, 2'd1);
    pulse(0, 0, 0, 1);
    check_output("timeout_p2", 18'h00429, 4'd2, 1'b0, 2'b00, 2'd1);

    // Draw: X O X / X O O / O X X.
    new_game();
    place_at(0); place_at(1); place_at(2); place_at(4);
    place_at(3); place_at(5); place_at(7); place_at(6);
    for (int k = 0; k < 9 && tb_cursor != 8; k++) press_next();
    check_output("pre_draw", 18'h06A59, 4'd8, 1'b0, 2'b00, 2'd1);
    apply_stimulus(0, 0, 1, 0);
    check_output("draw_n_plus_1", 18'h16A59, 4'd8, 1'b0, 2'b00, 2'd2);
    apply_stimulus(0, 0, 0, 0);
    check_output("draw_n_plus_2", 18'h16A59, 4'd8, 1'b0, 2'b11, 2'd3);

    // Random play against the model.
    rst = 1'b0;
    btn_start = 0; btn_next = 0; btn_sel = 0; tick = 0;
    model_reset();
    @(negedge clk) rst = 1'b1;
    s = 0; n = 0; p = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) s = ~s;
      if ($urandom_range(0, 2) == 0) n = ~n;
      if ($urandom_range(0, 2) == 0) p = ~p;
      btn_start = s; btn_next = n; btn_sel = p;
      tick = ($urandom_range(0, 3) == 0);
      @(posedge clk);
      model_step(s, n, p, tick);
      #1;
      check_output($sformatf("rand%0d", i), pack_model(), 4'(m_cursor), 1'(m_turn),
                   2'(m_winner), 2'(m_phase));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
